// File: rtl/ats_timer_array_if.sv
// Command/response bundle for ats_timer_array.
// Ports: a_req/a_cmd/b_req/b_cmd (client -> block); a_stat/b_stat,
// rd_valid/rd_data, alarm (block -> client).
interface ats_timer_array_if #(
    parameter int NUM_ALARMS = 24,
    parameter int COUNT_W    = 16
);
    logic                  a_req;
    logic [31:0]           a_cmd;
    logic [1:0]            a_stat;
    logic                  b_req;
    logic [31:0]           b_cmd;
    logic [1:0]            b_stat;
    logic                  rd_valid;
    logic [COUNT_W-1:0]    rd_data;
    logic [NUM_ALARMS-1:0] alarm;

    modport master (
        output a_req, a_cmd, b_req, b_cmd,
        input  a_stat, b_stat, rd_valid, rd_data, alarm
    );
    modport slave (
        input  a_req, a_cmd, b_req, b_cmd,
        output a_stat, b_stat, rd_valid, rd_data, alarm
    );
endinterface

// File: rtl/ats_timer_array.sv
// Multi-clock/alarm/timer array with two command clients.
// Ports: clk, reset (async active-low), bus (slave side of ats_timer_array_if).
module ats_timer_array #(
    parameter int NUM_CLOCKS = 16,
    parameter int NUM_ALARMS = 24,
    parameter int COUNT_W    = 16,
    parameter int PULSE_LEN  = 2
) (
    input  logic             clk,
    input  logic             reset,
    ats_timer_array_if.slave bus
);
    localparam int CIW = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1;
    localparam int PW  = $clog2(PULSE_LEN + 1);
    localparam logic [5:0] NCLK = 6'(NUM_CLOCKS);
    localparam logic [5:0] NALM = 6'(NUM_ALARMS);
    localparam logic [PW-1:0] PLEN = PW'(PULSE_LEN);
    localparam logic [PW-1:0] PONE = PW'(1);

    typedef logic [COUNT_W-1:0] cnt_t;
    localparam cnt_t ONE = cnt_t'(1);

    cnt_t                  cnt_q  [NUM_CLOCKS];
    cnt_t                  cnt_d  [NUM_CLOCKS];
    logic [1:0]            rate_q [NUM_CLOCKS];
    logic [1:0]            rate_d [NUM_CLOCKS];
    logic [NUM_CLOCKS-1:0] cen_q, cen_d, adv;

    cnt_t                  val_q  [NUM_ALARMS];
    cnt_t                  val_d  [NUM_ALARMS];
    cnt_t                  dur_q  [NUM_ALARMS];
    cnt_t                  dur_d  [NUM_ALARMS];
    logic [CIW-1:0]        sel_q  [NUM_ALARMS];
    logic [CIW-1:0]        sel_d  [NUM_ALARMS];
    logic [PW-1:0]         pcnt_q [NUM_ALARMS];
    logic [PW-1:0]         pcnt_d [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] sen_q, sen_d, rep_q, rep_d;
    logic [NUM_ALARMS-1:0] tmr_q, tmr_d, fire_q, fire_d;

    logic [2:0]   p_q, p_d;
    logic         act_q, act_d;
    logic [3:0]   perm_q, perm_d;  // {a_clk, a_alm, b_clk, b_alm}
    logic [1:0]   a_stat_q, a_stat_d, b_stat_q, b_stat_d;
    logic         rdv_q, rdv_d;
    cnt_t         rdd_q, rdd_d;

    logic [31:0]  cm [2];
    logic [2:0]   op_a, op_b;
    logic [4:0]   ix_a, ix_b;
    logic         clash, rd_tie, gnt_a, gnt_b, nak_a, nak_b;
    logic [1:0]   g;
    logic         unused_cmd;

    function automatic logic rate_hit(input logic [1:0] r, input logic [2:0] p);
        unique case (r)
            2'd0:    rate_hit = 1'b1;
            2'd1:    rate_hit = p[0];
            2'd2:    rate_hit = &p[1:0];
            default: rate_hit = &p;
        endcase
    endfunction

    function automatic logic legal(input logic [31:0] c, input logic act,
                                   input logic pclk, input logic palm,
                                   input logic is_a);
        logic ci, ai, si;
        ci = {1'b0, c[28:24]} < NCLK;
        ai = {1'b0, c[28:24]} < NALM;
        si = {1'b0, c[20:16]} < NCLK;
        unique case (c[31:29])
            3'd0:       legal = 1'b0;
            3'd1, 3'd2: legal = act && pclk && ci;
            3'd3:       legal = is_a;
            3'd4:       legal = act && ci;
            3'd5, 3'd6: legal = act && palm && ai && si;
            default:    legal = act && palm && ai;
        endcase
    endfunction

    // Arbitration: same-target writes cancel each other, A wins reads.
    always_comb begin
        cm[0]  = bus.a_cmd;
        cm[1]  = bus.b_cmd;
        op_a   = bus.a_cmd[31:29];
        op_b   = bus.b_cmd[31:29];
        ix_a   = bus.a_cmd[28:24];
        ix_b   = bus.b_cmd[28:24];
        clash  = bus.a_req && bus.b_req && (ix_a == ix_b) &&
                 (((op_a == 3'd1 || op_a == 3'd2) &&
                   (op_b == 3'd1 || op_b == 3'd2)) ||
                  (op_a >= 3'd5 && op_b >= 3'd5));
        rd_tie = bus.a_req && bus.b_req && op_a == 3'd4 && op_b == 3'd4;
        gnt_a  = bus.a_req && !clash &&
                 legal(bus.a_cmd, act_q, perm_q[3], perm_q[2], 1'b1);
        gnt_b  = bus.b_req && !clash && !rd_tie &&
                 legal(bus.b_cmd, act_q, perm_q[1], perm_q[0], 1'b0);
        nak_a  = bus.a_req && op_a != 3'd0 && !gnt_a;
        nak_b  = bus.b_req && op_b != 3'd0 && !gnt_b;
        g      = {gnt_b, gnt_a};
    end

    assign unused_cmd = ^{cm[0], cm[1]};

    always_comb begin
        logic kill;
        kill     = 1'b0;
        p_d      = act_q ? p_q + 3'd1 : p_q;
        act_d    = act_q;
        perm_d   = perm_q;
        if (gnt_a && op_a == 3'd3) begin
            act_d  = bus.a_cmd[28];
            perm_d = bus.a_cmd[27:24];
        end
        rdv_d = 1'b0;
        rdd_d = '0;
        if (gnt_a && op_a == 3'd4) begin
            rdv_d = 1'b1;
            rdd_d = cnt_q[ix_a[CIW-1:0]];
        end else if (gnt_b && op_b == 3'd4) begin
            rdv_d = 1'b1;
            rdd_d = cnt_q[ix_b[CIW-1:0]];
        end
        a_stat_d = gnt_a ? 2'b01 : (nak_a ? 2'b10 : 2'b00);
        b_stat_d = gnt_b ? 2'b01 : (nak_b ? 2'b10 : 2'b00);

        for (int i = 0; i < NUM_CLOCKS; i++) begin
            cnt_d[i]  = cnt_q[i];
            rate_d[i] = rate_q[i];
            cen_d[i]  = cen_q[i];
            adv[i]    = act_q && cen_q[i] && rate_hit(rate_q[i], p_q);
            for (int c = 0; c < 2; c++) begin
                if (g[c] && cm[c][28:24] == 5'(i)) begin
                    if (cm[c][31:29] == 3'd1) begin
                        // a load beats a same-cycle tick
                        cnt_d[i]  = cm[c][COUNT_W-1:0];
                        rate_d[i] = cm[c][23:22];
                        cen_d[i]  = 1'b1;
                        adv[i]    = 1'b0;
                    end else if (cm[c][31:29] == 3'd2) begin
                        cen_d[i] = cm[c][23];
                    end
                end
            end
            if (adv[i]) cnt_d[i] = cnt_q[i] + ONE;
        end

        for (int s = 0; s < NUM_ALARMS; s++) begin
            val_d[s] = val_q[s];
            dur_d[s] = dur_q[s];
            sel_d[s] = sel_q[s];
            sen_d[s] = sen_q[s];
            rep_d[s] = rep_q[s];
            tmr_d[s] = tmr_q[s];
            kill     = 1'b0;
            fire_d[s] = sen_q[s] && adv[sel_q[s]] &&
                        (cnt_q[sel_q[s]] + ONE == val_q[s]);
            if (fire_d[s]) begin
                if (tmr_q[s] && rep_q[s]) val_d[s] = val_q[s] + dur_q[s];
                else if (!rep_q[s])       sen_d[s] = 1'b0;
            end
            for (int c = 0; c < 2; c++) begin
                if (g[c] && cm[c][28:24] == 5'(s) && cm[c][31:29] >= 3'd5) begin
                    fire_d[s] = 1'b0;
                    unique case (cm[c][31:29])
                        3'd5: begin
                            val_d[s] = cm[c][COUNT_W-1:0];
                            sel_d[s] = cm[c][16 +: CIW];
                            rep_d[s] = cm[c][23];
                            tmr_d[s] = 1'b0;
                            sen_d[s] = 1'b1;
                        end
                        3'd6: begin
                            val_d[s] = cnt_q[cm[c][16 +: CIW]] + cm[c][COUNT_W-1:0];
                            dur_d[s] = cm[c][COUNT_W-1:0];
                            sel_d[s] = cm[c][16 +: CIW];
                            rep_d[s] = cm[c][23];
                            tmr_d[s] = 1'b1;
                            sen_d[s] = 1'b1;
                        end
                        default: begin
                            sen_d[s] = cm[c][23];
                            kill     = !cm[c][23];
                        end
                    endcase
                end
            end
            // fire is registered once, so the pulse starts an edge later
            if (kill)                pcnt_d[s] = '0;
            else if (fire_q[s])      pcnt_d[s] = PLEN;
            else if (pcnt_q[s] != 0) pcnt_d[s] = pcnt_q[s] - PONE;
            else                     pcnt_d[s] = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CLOCKS; i++) begin
                cnt_q[i]  <= '0;
                rate_q[i] <= '0;
            end
            for (int s = 0; s < NUM_ALARMS; s++) begin
                val_q[s]  <= '0;
                dur_q[s]  <= '0;
                sel_q[s]  <= '0;
                pcnt_q[s] <= '0;
            end
            cen_q    <= '0;
            sen_q    <= '0;
            rep_q    <= '0;
            tmr_q    <= '0;
            fire_q   <= '0;
            p_q      <= '0;
            act_q    <= 1'b1;
            perm_q   <= '1;
            a_stat_q <= '0;
            b_stat_q <= '0;
            rdv_q    <= 1'b0;
            rdd_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            rate_q   <= rate_d;
            val_q    <= val_d;
            dur_q    <= dur_d;
            sel_q    <= sel_d;
            pcnt_q   <= pcnt_d;
            cen_q    <= cen_d;
            sen_q    <= sen_d;
            rep_q    <= rep_d;
            tmr_q    <= tmr_d;
            fire_q   <= fire_d;
            p_q      <= p_d;
            act_q    <= act_d;
            perm_q   <= perm_d;
            a_stat_q <= a_stat_d;
            b_stat_q <= b_stat_d;
            rdv_q    <= rdv_d;
            rdd_q    <= rdd_d;
        end
    end

    assign bus.a_stat   = a_stat_q;
    assign bus.b_stat   = b_stat_q;
    assign bus.rd_valid = rdv_q;
    assign bus.rd_data  = rdd_q;

    always_comb begin
        for (int s = 0; s < NUM_ALARMS; s++) bus.alarm[s] = (pcnt_q[s] != '0);
    end
endmodule

// File: tb/tb_ats_timer_array.sv
// Self-checking bench for ats_timer_array.
// Main instance (16-bit) plus a COUNT_W=4 instance for the wrap/repeat case.
module tb_ats_timer_array;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ats_timer_array_if #(.NUM_ALARMS(24), .COUNT_W(16)) ifa ();
    ats_timer_array_if #(.NUM_ALARMS(24), .COUNT_W(4))  ifs ();

    ats_timer_array #(
        .NUM_CLOCKS(16), .NUM_ALARMS(24), .COUNT_W(16), .PULSE_LEN(2)
    ) u_dut (.clk(clk), .reset(reset), .bus(ifa));

    ats_timer_array #(
        .NUM_CLOCKS(16), .NUM_ALARMS(24), .COUNT_W(4), .PULSE_LEN(2)
    ) u_small (.clk(clk), .reset(reset), .bus(ifs));

    int n_pass = 0;
    int n_tot  = 0;

    typedef struct {
        string       nm;
        bit          ar;
        logic [31:0] ac;
        bit          br;
        logic [31:0] bc;
        logic [1:0]  ea;
        logic [1:0]  eb;
        bit          rd;
        logic [15:0] ed;
    } vec_t;

    vec_t        tv [13];
    logic [15:0] vals [30];
    int          t1, t2, t3, ms, pp;
    logic [15:0] v1, v2, v3;
    logic [23:0] exp_al;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %h, want %h", nm, act, exp);
        else n_pass++;
    endtask

    function automatic logic [31:0] cw(input logic [2:0] op, input logic [4:0] ix,
                                       input logic [1:0] f, input logic [4:0] cs,
                                       input logic [15:0] v);
        return {op, ix, f, 1'b0, cs, v};
    endfunction

    task automatic step(input bit s, input bit ar, input logic [31:0] ac,
                        input bit br, input logic [31:0] bc);
        if (s) begin
            ifs.a_req = ar; ifs.a_cmd = ac; ifs.b_req = br; ifs.b_cmd = bc;
        end else begin
            ifa.a_req = ar; ifa.a_cmd = ac; ifa.b_req = br; ifa.b_cmd = bc;
        end
        @(posedge clk);
        #1;
        ifa.a_req = 1'b0; ifa.b_req = 1'b0;
        ifs.a_req = 1'b0; ifs.b_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        ifa.a_req = 0; ifa.a_cmd = '0; ifa.b_req = 0; ifa.b_cmd = '0;
        ifs.a_req = 0; ifs.a_cmd = '0; ifs.b_req = 0; ifs.b_cmd = '0;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        idle(10);

        chk("rst_alarm",  ifa.alarm,    0);
        chk("rst_astat",  ifa.a_stat,   0);
        chk("rst_bstat",  ifa.b_stat,   0);
        chk("rst_rdv",    ifa.rd_valid, 0);
        chk("rst_rdd",    ifa.rd_data,  0);
        chk("rst_s_alm",  ifs.alarm,    0);
        chk("rst_s_stat", {ifs.a_stat, ifs.b_stat}, 0);
        chk("rst_s_rdv",  ifs.rd_valid, 0);

        tv[0]  = '{"nop",      1, cw(0, 0, 0, 0, 0),       0, 0, 2'b00, 2'b00, 0, 0};
        tv[1]  = '{"rd3",      1, cw(4, 3, 0, 0, 0),       0, 0, 2'b01, 2'b00, 1, 0};
        tv[2]  = '{"rd_oor",   1, cw(4, 16, 0, 0, 0),      0, 0, 2'b10, 2'b00, 0, 0};
        tv[3]  = '{"alm_oor",  1, cw(5, 24, 0, 0, 5),      0, 0, 2'b10, 2'b00, 0, 0};
        tv[4]  = '{"b_mode",   0, 0, 1, cw(3, 5'h1f, 0, 0, 0), 2'b00, 2'b10, 0, 0};
        tv[5]  = '{"alm_conf", 1, cw(5, 4, 0, 5, 5),
                                  1, cw(6, 4, 2'b10, 5, 3), 2'b10, 2'b10, 0, 0};
        tv[6]  = '{"rd_both",  1, cw(4, 3, 0, 0, 0),
                                  1, cw(4, 3, 0, 0, 0),     2'b01, 2'b10, 1, 0};
        tv[7]  = '{"clk_conf", 1, cw(1, 9, 0, 0, 16'h1234),
                                  1, cw(2, 9, 2'b10, 0, 0), 2'b10, 2'b10, 0, 0};
        tv[8]  = '{"en_diff",  1, cw(2, 3, 0, 0, 0),
                                  1, cw(2, 4, 0, 0, 0),     2'b01, 2'b01, 0, 0};
        tv[9]  = '{"csel_oor", 0, 0, 1, cw(5, 5, 2'b10, 20, 3), 2'b00, 2'b10, 0, 0};
        tv[10] = '{"mode_both", 1, cw(3, 5'h1f, 0, 0, 0),
                                  1, cw(3, 5'h1f, 0, 0, 0), 2'b01, 2'b10, 0, 0};
        tv[11] = '{"rd9",      1, cw(4, 9, 0, 0, 0),       0, 0, 2'b01, 2'b00, 1, 0};
        tv[12] = '{"b_rd12",   0, 0, 1, cw(4, 12, 0, 0, 0), 2'b00, 2'b01, 1, 0};

        for (int i = 0; i < 13; i++) begin
            step(0, tv[i].ar, tv[i].ac, tv[i].br, tv[i].bc);
            chk({tv[i].nm, "/a"},   ifa.a_stat,   tv[i].ea);
            chk({tv[i].nm, "/b"},   ifa.b_stat,   tv[i].eb);
            chk({tv[i].nm, "/rdv"}, ifa.rd_valid, tv[i].rd);
            if (tv[i].rd) chk({tv[i].nm, "/rdd"}, ifa.rd_data, tv[i].ed);
        end

        // rate 11 wrap and spacing
        step(0, 1, cw(1, 2, 2'b11, 0, 16'hFFFE), 0, 0);
        chk("r11_set", ifa.a_stat, 2'b01);
        for (int j = 0; j < 30; j++) begin
            step(0, 1, cw(4, 2, 0, 0, 0), 0, 0);
            vals[j] = ifa.rd_data;
        end
        t1 = -1; t2 = -1; t3 = -1;
        for (int j = 1; j < 30; j++) begin
            if (vals[j] !== vals[j-1]) begin
                if (t1 < 0)      t1 = j;
                else if (t2 < 0) t2 = j;
                else if (t3 < 0) t3 = j;
            end
        end
        v1 = (t1 > 0) ? vals[t1] : 16'hDEAD;
        v2 = (t2 > 0) ? vals[t2] : 16'hDEAD;
        v3 = (t3 > 0) ? vals[t3] : 16'hDEAD;
        chk("r11_first", vals[0], 16'hFFFE);
        chk("r11_phase", 32'(t1 >= 1 && t1 <= 8), 1);
        chk("r11_inc1",  v1, 16'hFFFF);
        chk("r11_wrap",  v2, 16'h0000);
        chk("r11_inc3",  v3, 16'h0001);
        chk("r11_gap1",  32'(t2 - t1), 8);
        chk("r11_gap2",  32'(t3 - t2), 8);

        // clock 5 passes value 5: slot 4 must stay idle after the conflict
        ms = cyc;
        step(0, 1, cw(1, 5, 0, 0, 0), 0, 0);
        chk("c5_set", ifa.a_stat, 2'b01);
        step(0, 1, cw(1, 1, 0, 0, 100), 0, 0);
        chk("c1_set", ifa.a_stat, 2'b01);
        step(0, 1, cw(6, 7, 2'b10, 1, 10), 0, 0);
        chk("t7_set", ifa.a_stat, 2'b01);
        for (int k = 1; k <= 35; k++) begin
            idle(1);
            exp_al = (k >= 10 && (k % 10) < 2) ? 24'h80 : 24'h0;
            chk($sformatf("tmr_k%0d", k), ifa.alarm, exp_al);
        end

        // freeze and resume
        pp = cyc;
        step(0, 1, cw(3, 5'b00111, 0, 0, 0), 1, cw(4, 5, 0, 0, 0));
        chk("off_mode", ifa.a_stat, 2'b01);
        chk("off_rd",   ifa.b_stat, 2'b01);
        chk("off_rdd",  ifa.rd_data, 16'(pp - ms - 1));
        step(0, 1, cw(1, 6, 0, 0, 7), 0, 0);
        chk("off_setclk", ifa.a_stat, 2'b10);
        step(0, 0, 0, 1, cw(4, 5, 0, 0, 0));
        chk("off_brd", ifa.b_stat, 2'b10);
        idle(5);
        step(0, 1, cw(3, 5'h1f, 0, 0, 0), 0, 0);
        chk("on_mode", ifa.a_stat, 2'b01);
        step(0, 1, cw(4, 5, 0, 0, 0), 0, 0);
        chk("on_rd1", ifa.rd_data, 16'(pp - ms));
        step(0, 1, cw(4, 5, 0, 0, 0), 0, 0);
        chk("on_rd2", ifa.rd_data, 16'(pp - ms + 1));

        // 4-bit repeat alarm, then disable mid-pulse
        step(1, 1, cw(5, 5, 2'b10, 0, 3), 0, 0);
        chk("s_alm_set", ifs.a_stat, 2'b01);
        step(1, 1, cw(1, 0, 0, 0, 0), 0, 0);
        chk("s_clk_set", ifs.a_stat, 2'b01);
        for (int k = 1; k <= 36; k++) begin
            idle(1);
            exp_al = ((k % 16) == 4 || (k % 16) == 5) ? 24'h20 : 24'h0;
            chk($sformatf("rep_k%0d", k), ifs.alarm, exp_al);
        end
        step(1, 1, cw(7, 5, 2'b00, 0, 0), 0, 0);
        chk("s_dis_ack", ifs.a_stat, 2'b01);
        chk("s_dis_clr", ifs.alarm, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
